// File: rtl/inst_rom_arb_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package inst_rom_arb_pkg;

    localparam int          InstAddrBus     = 32;
    localparam int          InstBus         = 64;
    localparam logic [63:0] ZeroDoubleWord  = 64'h0;
    localparam logic        ChipEnable      = 1'b1;
    localparam logic        ChipDisable     = 1'b0;
    localparam int          ArbMemWordsLog2 = 10;

    typedef enum logic [1:0] {
        ArbIdle = 2'b00,
        ArbRead = 2'b01,
        ArbAck  = 2'b10
    } arb_state_t;

    typedef enum logic {
        ArbGntIf  = 1'b0,
        ArbGntDbg = 1'b1
    } arb_gnt_t;

endpackage

// File: rtl/inst_rom_arb_rr.sv
// Two-request round-robin picker (fetch vs debug), purely combinational.
// Latency: zero; the grant follows the requests in the same cycle.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: req_if/req_dbg requests, last_grant history, gnt_vld/gnt result.
module rr_arb2
    import inst_rom_arb_pkg::*;
(
    input  logic     req_if,
    input  logic     req_dbg,
    input  arb_gnt_t last_grant,
    output logic     gnt_vld,
    output arb_gnt_t gnt
);

    always_comb begin
        gnt_vld = req_if | req_dbg;
        gnt     = ArbGntIf;
        if (req_if && req_dbg) begin
            // On a tie the port that did not win last time goes first.
            gnt = (last_grant == ArbGntIf) ? ArbGntDbg : ArbGntIf;
        end else if (req_dbg) begin
            gnt = ArbGntDbg;
        end
    end

endmodule

// File: rtl/inst_rom_arb.sv
// Arbitrates fetch and debug reads onto the single combinational ROM port.
// Latency: req sampled at E0, rom_ce/rom_addr after E0, ack + data after E1.
// Backpressure: req is held until ack; one transfer per two cycles.
// Debug port is only live when INST_ARB_DBG_EN is defined; otherwise its
// outputs are tied off and fetch is always granted.
// Ports: clk/rst (async active-low), if_* fetch port, dbg_* debug port,
//        rom_ce/rom_addr to the ROM, rom_inst from the ROM.
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int ADDR_W    = InstAddrBus,
    parameter int DATA_W    = InstBus,
    parameter int MEM_WORDS = 1 << ArbMemWordsLog2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_inst,
    output logic              dbg_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int                MEM_LOG2 = $clog2(MEM_WORDS);
    localparam logic [DATA_W-1:0] ZERO_W   = DATA_W'(ZeroDoubleWord);

    arb_state_t        state, state_nxt;
    arb_gnt_t          pick_gnt, cur_gnt;
    logic              pick_vld, pick_err, cur_err, take_grant;
    logic [ADDR_W-1:0] pick_addr;

`ifdef INST_ARB_DBG_EN
    arb_gnt_t last_grant;

    rr_arb2 u_rr (
        .req_if     (if_req),
        .req_dbg    (dbg_req),
        .last_grant (last_grant),
        .gnt_vld    (pick_vld),
        .gnt        (pick_gnt)
    );

    assign pick_addr = (pick_gnt == ArbGntDbg) ? dbg_addr : if_addr;
`else
    logic unused_dbg;

    assign pick_vld   = if_req;
    assign pick_gnt   = ArbGntIf;
    assign pick_addr  = if_addr;
    assign unused_dbg = ^{dbg_req, dbg_addr};
`endif

    // Misaligned, or any address bit above the word index set.
    assign pick_err = (pick_addr[2:0] != 3'b000) ||
                      ((pick_addr >> (MEM_LOG2 + 3)) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ArbIdle;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_grant = 1'b0;
        case (state)
            ArbIdle, ArbAck: begin
                // ACK behaves like IDLE so a held req gets a 2-cycle cadence.
                if (pick_vld) begin
                    take_grant = 1'b1;
                    state_nxt  = ArbRead;
                end else begin
                    state_nxt  = ArbIdle;
                end
            end
            ArbRead: state_nxt = ArbAck;
            default: state_nxt = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_ce   <= ChipDisable;
            rom_addr <= '0;
            cur_gnt  <= ArbGntIf;
            cur_err  <= 1'b0;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_inst  <= ZERO_W;
        end else begin
            if_ack <= 1'b0;
            if (take_grant) begin
                rom_addr <= pick_addr;
                rom_ce   <= pick_err ? ChipDisable : ChipEnable;
                cur_gnt  <= pick_gnt;
                cur_err  <= pick_err;
            end
            if (state == ArbRead) begin
                rom_ce <= ChipDisable;
                if (cur_gnt == ArbGntIf) begin
                    if_ack  <= 1'b1;
                    if_err  <= cur_err;
                    if_inst <= cur_err ? ZERO_W : rom_inst;
                end
            end
        end
    end

`ifdef INST_ARB_DBG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= ArbGntDbg;
            dbg_ack    <= 1'b0;
            dbg_err    <= 1'b0;
            dbg_inst   <= ZERO_W;
        end else begin
            dbg_ack <= 1'b0;
            if (take_grant) last_grant <= pick_gnt;
            if ((state == ArbRead) && (cur_gnt == ArbGntDbg)) begin
                dbg_ack  <= 1'b1;
                dbg_err  <= cur_err;
                dbg_inst <= cur_err ? ZERO_W : rom_inst;
            end
        end
    end
`else
    assign dbg_ack  = 1'b0;
    assign dbg_err  = 1'b0;
    assign dbg_inst = ZERO_W;
`endif

endmodule

// File: tb/tb_inst_rom_arb.sv
// Directed self-checking bench for inst_rom_arb with a behavioural ROM.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_inst_rom_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack, if_err;
    logic [63:0] if_inst;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic        dbg_ack, dbg_err;
    logic [63:0] dbg_inst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [63:0] rom_inst;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_inst = {32'hA5A5A5A5, rom_addr};

    inst_rom_arb #(.ADDR_W(32), .DATA_W(64), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_inst(if_inst), .if_err(if_err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
        .dbg_inst(dbg_inst), .dbg_err(dbg_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL reset_rom_ce got=%0b exp=0", rom_ce); end
        checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL reset_if_ack got=%0b exp=0", if_ack); end
        checks++; if (if_err !== 1'b0) begin failures++; $display("FAIL reset_if_err got=%0b exp=0", if_err); end
        checks++; if (if_inst !== 64'h0) begin failures++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
        checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_dbg_ack got=%0b exp=0", dbg_ack); end
        checks++; if (dbg_inst !== 64'h0) begin failures++; $display("FAIL reset_dbg_inst got=%h exp=0", dbg_inst); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        checks++; if (rom_ce !== 1'b1) begin failures++; $display("FAIL single_rom_ce got=%0b exp=1", rom_ce); end
        checks++; if (rom_addr !== 32'h10) begin failures++; $display("FAIL single_rom_addr got=%h exp=10", rom_addr); end
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL single_early_ack got=%0b exp=0", if_ack); end
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL single_ack got=%0b exp=1", if_ack); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000010) begin failures++; $display("FAIL single_inst got=%h exp=a5a5a5a500000010", if_inst); end
        checks++; if (if_err !== 1'b0) begin failures++; $display("FAIL single_err got=%0b exp=0", if_err); end
        checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL single_ce_drop got=%0b exp=0", rom_ce); end
        if_req = 1'b0;
        tick();
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL single_ack_pulse got=%0b exp=0", if_ack); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000010) begin failures++; $display("FAIL single_hold got=%h exp=a5a5a5a500000010", if_inst); end
        tick();
    endtask

    task automatic test_back_to_back;
        if_req = 1'b1; if_addr = 32'h08;
        tick();
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%0b exp=1", if_ack); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000008) begin failures++; $display("FAIL b2b_inst1 got=%h exp=a5a5a5a500000008", if_inst); end
        if_addr = 32'h18;
        tick();
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%0b exp=0", if_ack); end
        checks++; if (rom_addr !== 32'h18) begin failures++; $display("FAIL b2b_rom_addr got=%h exp=18", rom_addr); end
        if_addr = 32'h40; // must be ignored: already registered
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack2 got=%0b exp=1", if_ack); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000018) begin failures++; $display("FAIL b2b_inst2 got=%h exp=a5a5a5a500000018", if_inst); end
        if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_error;
        logic saw_ce;
        if_req = 1'b1; if_addr = 32'h0C;
        tick();
        saw_ce = rom_ce;
        tick();
        saw_ce = saw_ce | rom_ce;
        checks++; if (saw_ce !== 1'b0) begin failures++; $display("FAIL err_mis_ce got=%0b exp=0", saw_ce); end
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL err_mis_ack got=%0b exp=1", if_ack); end
        checks++; if (if_err !== 1'b1) begin failures++; $display("FAIL err_mis_err got=%0b exp=1", if_err); end
        checks++; if (if_inst !== 64'h0) begin failures++; $display("FAIL err_mis_inst got=%h exp=0", if_inst); end
        if_addr = 32'h2000;
        tick();
        checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL err_range_ce got=%0b exp=0", rom_ce); end
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL err_range_ack got=%0b exp=1", if_ack); end
        checks++; if (if_err !== 1'b1) begin failures++; $display("FAIL err_range_err got=%0b exp=1", if_err); end
        if_addr = 32'h1FF8;
        tick();
        checks++; if (rom_ce !== 1'b1) begin failures++; $display("FAIL top_word_ce got=%0b exp=1", rom_ce); end
        tick();
        checks++; if (if_err !== 1'b0) begin failures++; $display("FAIL top_word_err got=%0b exp=0", if_err); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00001FF8) begin failures++; $display("FAIL top_word_inst got=%h exp=a5a5a5a500001ff8", if_inst); end
        if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_in_read;
        logic saw_ack;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        checks++; if (rom_ce !== 1'b1) begin failures++; $display("FAIL rst_read_enter got=%0b exp=1", rom_ce); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL rst_async_ce got=%0b exp=0", rom_ce); end
        checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL rst_async_addr got=%h exp=0", rom_addr); end
        checks++; if (if_inst !== 64'h0) begin failures++; $display("FAIL rst_async_inst got=%h exp=0", if_inst); end
        tick();
        saw_ack = if_ack;
        tick();
        saw_ack = saw_ack | if_ack;
        checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL rst_no_ack got=%0b exp=0", saw_ack); end
        if_addr = 32'h28;
        rst = 1'b1;
        tick();
        checks++; if (rom_addr !== 32'h28) begin failures++; $display("FAIL rst_fresh_addr got=%h exp=28", rom_addr); end
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL rst_fresh_ack got=%0b exp=1", if_ack); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000028) begin failures++; $display("FAIL rst_fresh_inst got=%h exp=a5a5a5a500000028", if_inst); end
        if_req = 1'b0;
        tick();
        tick();
    endtask

`ifdef INST_ARB_DBG_EN
    task automatic test_tie;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        if_req = 1'b1; if_addr = 32'h08;
        dbg_req = 1'b1; dbg_addr = 32'h20;
        tick();
        checks++; if (rom_addr !== 32'h08) begin failures++; $display("FAIL tie1_rom_addr got=%h exp=08", rom_addr); end
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL tie1_if_ack got=%0b exp=1", if_ack); end
        checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL tie1_dbg_ack got=%0b exp=0", dbg_ack); end
        tick();
        checks++; if (rom_addr !== 32'h20) begin failures++; $display("FAIL tie2_rom_addr got=%h exp=20", rom_addr); end
        tick();
        checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL tie2_dbg_ack got=%0b exp=1", dbg_ack); end
        checks++; if (dbg_inst !== 64'hA5A5A5A5_00000020) begin failures++; $display("FAIL tie2_dbg_inst got=%h exp=a5a5a5a500000020", dbg_inst); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000008) begin failures++; $display("FAIL tie2_if_hold got=%h exp=a5a5a5a500000008", if_inst); end
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL tie2_if_ack got=%0b exp=0", if_ack); end
        tick();
        tick();
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL tie3_if_ack got=%0b exp=1", if_ack); end
        if_req = 1'b0; dbg_req = 1'b0;
        tick();
        tick();
    endtask
`else
    task automatic test_config_off;
        logic saw_dbg;
        dbg_req = 1'b1; dbg_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h30;
        saw_dbg = dbg_ack;
        tick();
        saw_dbg = saw_dbg | dbg_ack;
        checks++; if (rom_addr !== 32'h30) begin failures++; $display("FAIL cfg_rom_addr got=%h exp=30", rom_addr); end
        tick();
        saw_dbg = saw_dbg | dbg_ack;
        checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL cfg_if_ack got=%0b exp=1", if_ack); end
        checks++; if (if_inst !== 64'hA5A5A5A5_00000030) begin failures++; $display("FAIL cfg_if_inst got=%h exp=a5a5a5a500000030", if_inst); end
        if_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_dbg = saw_dbg | dbg_ack;
        end
        checks++; if (saw_dbg !== 1'b0) begin failures++; $display("FAIL cfg_dbg_ack got=%0b exp=0", saw_dbg); end
        checks++; if (dbg_inst !== 64'h0) begin failures++; $display("FAIL cfg_dbg_inst got=%h exp=0", dbg_inst); end
        checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL cfg_idle_ack got=%0b exp=0", if_ack); end
        dbg_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_error();
        test_reset_in_read();
`ifdef INST_ARB_DBG_EN
        test_tie();
`else
        test_config_off();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
